apb_master_if: RTL
==================

// Module: apb_master_if
// PURPOSE
//  APB initiator: converts single-beat commands from an internal requester (CPU model, test
//  sequencer, bus bridge) into APB SETUP/ACCESS transfers toward the GPIO APB slave interface.
//  Waits on PREADY, returns read data or a timeout error on a one-cycle response strobe.
//  Sits at the bus-master end of the APB link; one outstanding transfer at a time.
// PARAMETERS
//  ADDR_WIDTH  4   PADDR / cmd_addr width
//  DATA_WIDTH  32  PWDATA / PRDATA / cmd_wdata / rsp_rdata width
//  TIMEOUT     16  max ACCESS cycles without PREADY before abort; 0 = wait forever
// PORTS
//  sys_clk    in   1           single clock; all logic on rising edge
//  sys_rst    in   1           synchronous, active-high reset
//  cmd_valid  in   1           command request
//  cmd_ready  out  1           high only in IDLE; command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1           1=write, 0=read
//  cmd_addr   in   ADDR_WIDTH  target register address
//  cmd_wdata  in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid  out  1           one-cycle pulse: transfer finished
//  rsp_err    out  1           valid with rsp_valid: 1 = timeout abort
//  rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on reads; 0 on writes/errors
//  PSEL       out  1           APB select
//  PENABLE    out  1           APB enable
//  PWRITE     out  1           APB direction
//  PADDR      out  ADDR_WIDTH  APB address
//  PWDATA     out  DATA_WIDTH  APB write data
//  PRDATA     in   DATA_WIDTH  APB read data
//  PREADY     in   1           APB ready (slave wait states)
// BEHAVIOUR
//  - Reset (sys_rst=1 at edge): state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0;
//    PADDR, PWDATA, rsp_rdata = 0; wait counter = 0; cmd_ready = 1 after reset releases.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all APB outputs registered.
//  - IDLE: cmd_ready=1. On accept, register addr/write/wdata; next cycle SETUP.
//    PWDATA loads cmd_wdata on writes, 0 on reads.
//  - SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; -> ACCESS.
//  - ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable for the whole phase.
//    PREADY=1 at edge: capture PRDATA (reads) -> RESP, rsp_err=0.
//    PREADY=0: counter++; when counter reaches TIMEOUT (TIMEOUT!=0) -> RESP, rsp_err=1,
//    rsp_rdata=0. PREADY and timeout in same cycle: PREADY wins (no error).
//  - RESP (1 cycle): PSEL=PENABLE=0, rsp_valid=1; counter cleared; -> IDLE.
//  - Latency: accept edge N; SETUP cycle N+1; ACCESS N+2; zero-wait rsp_valid cycle N+3.
//    Each PREADY wait state adds one cycle. Back-to-back throughput: 1 transfer / 4 cycles.
//  - cmd_valid while busy: ignored (cmd_ready=0); requester holds it until IDLE.
//  - rsp_valid is a pulse, no backpressure; rsp_rdata/rsp_err hold until next response.
//  - Counter width $clog2(TIMEOUT+1); saturates, never wraps.
//  - sys_rst mid-transfer: PSEL/PENABLE drop at that edge, no rsp_valid issued, back to IDLE.
// STRUCTURE
//  - apb_pkg: state enum (IDLE/SETUP/ACCESS/RESP), default ADDR/DATA widths.
//  - Sub-module apb_wait_timer: clear/enable/expire counter for TIMEOUT.
//  - Top: FSM, address/data/control registers, response registers.
// TESTING
//  - Write addr 0x0 data 0xABCD_1234, PREADY tied 1 -> PSEL@N+1, PENABLE@N+2,
//    PWDATA=0xABCD_1234 held both cycles, rsp_valid@N+3, rsp_err=0.
//  - Read addr 0xA, slave PRDATA=0xAAAA_BBBB, PREADY after 3 wait states -> ACCESS 4 cycles,
//    rsp_rdata=0xAAAA_BBBB, rsp_valid@N+6.
//  - Read addr 0x4, PREADY stuck 0, TIMEOUT=16 -> abort after 16 ACCESS cycles,
//    rsp_err=1, rsp_rdata=0, PSEL=0 in RESP.
//  - cmd_valid held continuously, writes 0x1..0x3 -> cmd_ready=0 during transfers,
//    accepts 4 cycles apart, exactly 3 rsp_valid pulses, no command lost or duplicated.
//  - sys_rst asserted during ACCESS of write 0xC -> next cycle PSEL=PENABLE=0,
//    no rsp_valid, cmd_ready=1 after release.
//  - PREADY and timeout coincide at 16th ACCESS cycle -> rsp_err=0, PRDATA captured.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator.
//   - apb_state_e    : transfer FSM states (IDLE/SETUP/ACCESS/RESP)
//   - APB_*_WIDTH    : default address/data widths for the GPIO APB link
//   - wait_cnt_width : width of the ACCESS wait-state counter for a given TIMEOUT
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 4;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // TIMEOUT=0 means "wait forever"; keep a 1-bit counter so widths stay legal.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-state counter.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset (counter -> 0)
//   i_clear  : synchronous clear (held while not in ACCESS)
//   i_enable : count one wait state (ACCESS with PREADY low)
//   o_expire : this wait state is the TIMEOUT-th one; abort at this edge
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW     = wait_cnt_width(TIMEOUT);
  localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] r_count;

  // Saturates at all-ones so a TIMEOUT=0 (wait forever) transfer never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The counter holds the number of wait states already seen, so the edge
  // that would bring it to TIMEOUT is the abort edge.
  assign o_expire = (TIMEOUT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/apb_master_if.sv
// APB initiator: turns single-beat commands into APB SETUP/ACCESS transfers,
// waits on PREADY (with optional timeout) and returns a one-cycle response.
// Ports:
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (accepted when both high)
//   cmd_write/addr/wdata    : command payload
//   rsp_valid/err/rdata     : response pulse, timeout flag, read data
//   PSEL..PREADY            : APB master-side signals
//   o_dbg_state             : current FSM state for observation
// Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, so the requester holds cmd_valid and its payload
// stable until that edge. rsp_valid has no ready: it is a single-cycle pulse and
// rsp_err/rsp_rdata hold their value until the next response.
module apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  output apb_state_e            o_dbg_state
);

  apb_state_e            r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic w_timer_clear;
  logic w_timer_en;
  logic w_expire;

  assign w_timer_clear = (r_state != ST_ACCESS);
  assign w_timer_en    = (r_state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk    (sys_clk),
    .i_rst    (sys_rst),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  // APB outputs are loaded one state early so they are registered values
  // during the state they belong to (e.g. PSEL is set on the accept edge).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= cmd_write;
            r_paddr   <= cmd_addr;
            r_pwdata  <= cmd_write ? cmd_wdata : '0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY is checked first so a ready on the timeout edge completes cleanly.
          if (PREADY) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_state     <= ST_RESP;
          end else if (w_expire) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rsp_rdata;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign o_dbg_state = r_state;

endmodule
